// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: decoded instruction codes, reset vector, target helpers
package cpu_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  localparam logic [6:0] CODE_BEQ    = 7'd30;
  localparam logic [6:0] CODE_BGEZ   = 7'd31;
  localparam logic [6:0] CODE_BGEZAL = 7'd32;
  localparam logic [6:0] CODE_BGTZ   = 7'd33;
  localparam logic [6:0] CODE_BLEZ   = 7'd34;
  localparam logic [6:0] CODE_BLTZ   = 7'd35;
  localparam logic [6:0] CODE_BLTZAL = 7'd36;
  localparam logic [6:0] CODE_BNE    = 7'd37;
  localparam logic [6:0] CODE_J      = 7'd38;
  localparam logic [6:0] CODE_JAL    = 7'd39;
  localparam logic [6:0] CODE_JALR   = 7'd40;
  localparam logic [6:0] CODE_JR     = 7'd41;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_JUMP,
    TGT_REG,
    TGT_BRANCH
  } target_sel_e;

  // Branch offset counts instruction words relative to the branch's own address.
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] offset);
    return pc + {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/pc_v2_if.sv
// rtl/pc_v2_if.sv - strobe, decode and address bus between the CPU control and the program counter
interface pc_v2_if;
  logic        fetch;
  logic        exec1;
  logic        exec2;
  logic [6:0]  internal_code;
  logic [15:0] offset;
  logic [25:0] instr_index;
  logic [31:0] register_data;
  logic        zero;
  logic        positive;
  logic        negative;
  logic [31:0] address;
  logic        halt;

  modport master (
    output fetch, exec1, exec2, internal_code, offset, instr_index, register_data,
           zero, positive, negative,
    input  address, halt
  );

  modport slave (
    input  fetch, exec1, exec2, internal_code, offset, instr_index, register_data,
           zero, positive, negative,
    output address, halt
  );
endinterface

// File: rtl/pc_branch_cond.sv
// rtl/pc_branch_cond.sv - decides whether the current instruction transfers control
module pc_branch_cond
  import cpu_pkg::*;
(
  input  logic [6:0] internal_code,
  input  logic       zero,
  input  logic       positive,
  input  logic       negative,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (internal_code)
      CODE_J, CODE_JAL, CODE_JR, CODE_JALR: taken = 1'b1;
      CODE_BEQ:                             taken = zero;
      CODE_BGEZ, CODE_BGEZAL:               taken = zero | positive;
      CODE_BGTZ:                            taken = positive;
      CODE_BLEZ:                            taken = zero | negative;
      CODE_BLTZ, CODE_BLTZAL:               taken = negative;
      CODE_BNE:                             taken = ~zero;
      default:                              taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_v2.sv
// rtl/pc_v2.sv - multicycle program counter with one delay slot and halt-on-address-zero
module pc_v2 #(
  parameter logic [31:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR
) (
  input  logic   clk,
  input  logic   reset,
  pc_v2_if.slave bus
);
  import cpu_pkg::*;

  logic [31:0] pc;
  logic [31:0] target;
  logic        pending;
  logic        halt_q;
  logic        taken;
  logic [31:0] pc_plus4;
  logic [31:0] next_target;
  target_sel_e sel;
  logic        unused_exec1;

  assign unused_exec1 = bus.exec1;
  assign pc_plus4     = pc + 32'd4;
  assign bus.address  = pc;
  assign bus.halt     = halt_q;

  pc_branch_cond u_cond (
    .internal_code (bus.internal_code),
    .zero          (bus.zero),
    .positive      (bus.positive),
    .negative      (bus.negative),
    .taken         (taken)
  );

  always_comb begin
    sel = TGT_NONE;
    case (bus.internal_code)
      CODE_J, CODE_JAL:                        sel = TGT_JUMP;
      CODE_JR, CODE_JALR:                      sel = TGT_REG;
      CODE_BEQ, CODE_BGEZ, CODE_BGEZAL, CODE_BGTZ,
      CODE_BLEZ, CODE_BLTZ, CODE_BLTZAL, CODE_BNE: sel = TGT_BRANCH;
      default:                                 sel = TGT_NONE;
    endcase
  end

  always_comb begin
    next_target = '0;
    case (sel)
      TGT_JUMP:   next_target = {pc_plus4[31:28], bus.instr_index, 2'b00};
      TGT_REG:    next_target = bus.register_data;
      TGT_BRANCH: next_target = branch_target(pc, bus.offset);
      default:    next_target = '0;
    endcase
  end

  // A transfer seen while pending is set sits in a delay slot and is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_VECTOR;
      pending <= 1'b0;
      target  <= '0;
      halt_q  <= 1'b0;
    end else if (bus.exec2) begin
      if (!halt_q) begin
        if (pending) begin
          pc      <= target;
          pending <= 1'b0;
        end else begin
          pc <= pc_plus4;
          if (taken) begin
            pending <= 1'b1;
            target  <= next_target;
          end
        end
      end
    end else if (bus.fetch && pc == 32'd0) begin
      halt_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_v2.sv
// tb/tb_pc_v2.sv - self-checking bench for pc_v2: directed table, branch sweep, random, reset and halt
module tb_pc_v2;
  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_v2_if bus ();
  pc_v2 dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic        m_halt;
  logic [31:0] m_q[$];

  typedef struct {
    logic [6:0]  code;
    logic [15:0] off;
    logic [25:0] idx;
    logic [31:0] rdata;
    int          r;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[17];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: comparator result r drives the condition directly.
  function automatic bit model_taken(input logic [6:0] code, input int r);
    case (code)
      7'd38, 7'd39, 7'd40, 7'd41: return 1'b1;
      7'd30:        return r == 0;
      7'd31, 7'd32: return r >= 0;
      7'd33:        return r > 0;
      7'd34:        return r <= 0;
      7'd35, 7'd36: return r < 0;
      7'd37:        return r != 0;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_target(input logic [6:0] code, input logic [31:0] pc,
                                               input logic [15:0] off, input logic [25:0] idx,
                                               input logic [31:0] rdata);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    if (code == 7'd38 || code == 7'd39) return {pc4[31:28], idx, 2'b00};
    if (code == 7'd40 || code == 7'd41) return rdata;
    return pc + 32'(int'($signed(off)) * 4);
  endfunction

  task automatic model_reset();
    m_pc   = RV;
    m_halt = 1'b0;
    m_q.delete();
  endtask

  task automatic step(input logic [6:0] code, input logic [15:0] off, input logic [25:0] idx,
                      input logic [31:0] rdata, input int r,
                      input bit has_exp, input logic [31:0] exp_addr);
    logic [31:0] nxt;
    @(negedge clk);
    check32("addr_fetch", bus.address, m_pc);
    check1("halt_fetch", bus.halt, m_halt);
    if (has_exp) check32("addr_table", bus.address, exp_addr);
    bus.exec2 = 1'b0;
    bus.fetch = 1'b1;
    @(negedge clk);
    if (m_pc == 32'd0) m_halt = 1'b1;
    check32("addr_exec1", bus.address, m_pc);
    check1("halt_exec1", bus.halt, m_halt);
    bus.fetch         = 1'b0;
    bus.exec1         = 1'b1;
    bus.internal_code = code;
    bus.offset        = off;
    bus.instr_index   = idx;
    bus.register_data = rdata;
    bus.zero          = (r == 0);
    bus.positive      = (r > 0);
    bus.negative      = (r < 0);
    @(negedge clk);
    check32("addr_exec2", bus.address, m_pc);
    bus.exec1 = 1'b0;
    bus.exec2 = 1'b1;
    if (!m_halt) begin
      if (m_q.size() != 0) begin
        nxt = m_q.pop_front();
      end else begin
        nxt = m_pc + 32'd4;
        if (model_taken(code, r)) m_q.push_back(model_target(code, m_pc, off, idx, rdata));
      end
      m_pc = nxt;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.fetch = 1'b0; bus.exec1 = 1'b0; bus.exec2 = 1'b0;
    reset = 1'b0;
    #2;
    model_reset();
    check32("reset_addr", bus.address, RV);
    check1("reset_halt", bus.halt, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] jt;
    int rv3[3];
    reset = 1'b0;
    bus.fetch = 1'b0; bus.exec1 = 1'b0; bus.exec2 = 1'b0;
    bus.internal_code = '0; bus.offset = '0; bus.instr_index = '0; bus.register_data = '0;
    bus.zero = 1'b0; bus.positive = 1'b0; bus.negative = 1'b0;
    model_reset();
    #12;
    check32("por_addr", bus.address, RV);
    check1("por_halt", bus.halt, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    tbl[0]  = '{7'd1,  16'd0,     26'd0,     32'd0, 1, 32'hBFC0_0000};
    tbl[1]  = '{7'd1,  16'd0,     26'd0,     32'd0, 1, 32'hBFC0_0004};
    tbl[2]  = '{7'd41, 16'd0,     26'd0,     32'd4, 1, 32'hBFC0_0008};
    tbl[3]  = '{7'd1,  16'd0,     26'd0,     32'd0, 1, 32'hBFC0_000C};
    tbl[4]  = '{7'd1,  16'd0,     26'd0,     32'd0, 1, 32'h0000_0004};
    tbl[5]  = '{7'd38, 16'd0,     26'd25000, 32'd0, 1, 32'h0000_0008};
    tbl[6]  = '{7'd1,  16'd0,     26'd0,     32'd0, 1, 32'h0000_000C};
    tbl[7]  = '{7'd1,  16'd0,     26'd0,     32'd0, 1, 32'd100000};
    tbl[8]  = '{7'd1,  16'd0,     26'd0,     32'd0, 1, 32'd100004};
    tbl[9]  = '{7'd39, 16'd0,     26'd50000, 32'd0, 1, 32'd100008};
    tbl[10] = '{7'd1,  16'd0,     26'd0,     32'd0, 1, 32'd100012};
    tbl[11] = '{7'd1,  16'd0,     26'd0,     32'd0, 1, 32'd200000};
    tbl[12] = '{7'd1,  16'd0,     26'd0,     32'd0, 1, 32'd200004};
    tbl[13] = '{7'd30, 16'd25000, 26'd0,     32'd0, 5, 32'd200008};
    tbl[14] = '{7'd30, 16'd25000, 26'd0,     32'd0, 0, 32'd200012};
    tbl[15] = '{7'd1,  16'd0,     26'd0,     32'd0, 1, 32'd200016};
    tbl[16] = '{7'd1,  16'd0,     26'd0,     32'd0, 1, 32'd300012};
    for (int i = 0; i < 17; i++)
      step(tbl[i].code, tbl[i].off, tbl[i].idx, tbl[i].rdata, tbl[i].r, 1'b1, tbl[i].exp);

    // Every conditional branch against negative, zero and positive results.
    rv3[0] = -3; rv3[1] = 0; rv3[2] = 7;
    for (int c = 30; c <= 37; c++)
      for (int k = 0; k < 3; k++) begin
        step(7'(c), 16'($urandom_range(0, 65535)), 26'd0, 32'd0, rv3[k], 1'b0, 32'd0);
        step(7'd1, 16'd0, 26'd0, 32'd0, 1, 1'b0, 32'd0);
      end

    // Transfer in a delay slot must lose to the pending jump target.
    a  = m_pc;
    jt = {a[31:28] + 4'(((a + 32'd4) >> 28) != (a >> 28)), 26'h0ABCDE, 2'b00};
    step(7'd38, 16'd0, 26'h0ABCDE, 32'd0, 1, 1'b1, a);
    step(7'd41, 16'd0, 26'd0, 32'h1234_5670, 1, 1'b1, a + 32'd4);
    step(7'd1, 16'd0, 26'd0, 32'd0, 1, 1'b1, jt);

    for (int i = 0; i < 300; i++) begin
      logic [6:0]  code;
      logic [31:0] rd;
      int          r;
      code = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(29, 41));
      rd   = $urandom | 32'h0000_0100;
      r    = int'($urandom_range(0, 2)) - 1;
      step(code, 16'($urandom), 26'($urandom), rd, r, 1'b0, 32'd0);
    end

    // Reset mid-instruction with a jump pending: pending must be discarded.
    do_reset();
    step(7'd38, 16'd0, 26'd12345, 32'd0, 1, 1'b0, 32'd0);
    @(negedge clk);
    bus.exec2 = 1'b0; bus.fetch = 1'b1;
    @(negedge clk);
    bus.fetch = 1'b0; bus.exec1 = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check32("midreset_addr", bus.address, RV);
    check1("midreset_halt", bus.halt, 1'b0);
    @(negedge clk);
    bus.exec1 = 1'b0;
    reset = 1'b1;
    step(7'd1, 16'd0, 26'd0, 32'd0, 1, 1'b1, RV);
    step(7'd1, 16'd0, 26'd0, 32'd0, 1, 1'b1, RV + 32'd4);
    step(7'd1, 16'd0, 26'd0, 32'd0, 1, 1'b1, RV + 32'd8);

    // JR to address 0 halts the CPU once address 0 is fetched.
    a = m_pc;
    step(7'd41, 16'd0, 26'd0, 32'd0, 1, 1'b1, a);
    step(7'd1, 16'd0, 26'd0, 32'd0, 1, 1'b1, a + 32'd4);
    step(7'd1, 16'd0, 26'd0, 32'd0, 1, 1'b1, 32'd0);
    check1("halt_set", bus.halt, 1'b1);
    step(7'd41, 16'd0, 26'd0, 32'h40, 1, 1'b1, 32'd0);
    step(7'd38, 16'd0, 26'd77, 32'd0, 1, 1'b1, 32'd0);
    step(7'd1, 16'd0, 26'd0, 32'd0, 1, 1'b1, 32'd0);
    @(negedge clk);
    check32("halt_frozen_addr", bus.address, 32'd0);
    check1("halt_sticky", bus.halt, 1'b1);
    do_reset();
    step(7'd1, 16'd0, 26'd0, 32'd0, 1, 1'b1, RV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
